// File: rtl/baby_beat_sequencer_pkg.sv
// Shared definitions for the Baby beat sequencer and the blocks that follow
// its timing (CI, PI, store control).
//   state_e   : sequencer FSM states
//   beat_e    : beat encoding within one instruction
//   DIGITS_DEF: digit times per beat
//   BEATS_DEF : beats per instruction
package baby_beat_sequencer_pkg;

   localparam int DIGITS_DEF = 32;
   localparam int BEATS_DEF  = 4;

   typedef enum logic [1:0] {
      ST_STOPPED  = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STEPPING = 2'd2,
      ST_HALTED   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      BEAT_SCAN1   = 2'd0,
      BEAT_ACTION1 = 2'd1,
      BEAT_SCAN2   = 2'd2,
      BEAT_ACTION2 = 2'd3
   } beat_e;

endpackage

// File: rtl/baby_beat_sequencer_digit_counter.sv
// Digit-time counter: counts 0..LAST and wraps to 0.
//   clk   : clock, rising edge
//   clear : synchronous clear to 0 (dominates en)
//   en    : advance by one this cycle
//   count : present digit time
//   tc    : terminal count, high while count == LAST
module baby_beat_sequencer_digit_counter #(
   parameter logic [4:0] LAST = 5'd31
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       en,
   output logic [4:0] count,
   output logic       tc
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= 5'd0;
      end else if (en) begin
         count <= (count == LAST) ? 5'd0 : count + 5'd1;
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/baby_beat_sequencer.sv
// Baby beat sequencer: generates digit/beat timing and per-beat strobes for
// the four-beat instruction cycle (SCAN1, ACTION1, SCAN2, ACTION2).
//   clk, reset            : clock; synchronous active-high reset
//   run                   : run/stop switch (level)
//   step                  : single-step key (level), used only when
//                           BABY_SINGLE_STEP_EN is defined
//   stop_instr            : STP decode, looked at only at ACTION2 digit 31
//   digit, beat           : present digit time and beat
//   ci_inc_en..exec_en    : strobes high for the whole of their beat
//   instr_done            : pulse on the last cycle of an instruction
//   stopped               : stop lamp
//   fsm_state             : present FSM state, for observation
// Optional feature macro: BABY_SINGLE_STEP_EN (enables the STEPPING state).
//
// Handshakes: none; every input is a level sampled on each rising clk edge,
// every output is a register.
module baby_beat_sequencer
   import baby_beat_sequencer_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int BEATS  = BEATS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       step,
   input  logic       stop_instr,
   output logic [4:0] digit,
   output logic [1:0] beat,
   output logic       ci_inc_en,
   output logic       pi_load_en,
   output logic       opnd_en,
   output logic       exec_en,
   output logic       instr_done,
   output logic       stopped,
   output state_e     fsm_state
);

   localparam logic [4:0] LAST_DIGIT = 5'(DIGITS - 1);
   localparam logic [1:0] LAST_BEAT  = 2'(BEATS - 1);

   state_e     state, next_state;
   logic       active, next_active, end_instr, tc, step_rise;
   logic [1:0] next_beat;
   logic [4:0] next_digit;

`ifdef BABY_SINGLE_STEP_EN
   logic step_q;
   always_ff @(posedge clk) begin
      if (reset) step_q <= 1'b0;
      else       step_q <= step;
   end
   assign step_rise = step & ~step_q;
`else
   logic unused_step;
   assign unused_step = step;
   assign step_rise   = 1'b0;
`endif

   // Counter runs only while an instruction is executing; otherwise it is
   // held at 0 so entering RUNNING/STEPPING always starts at digit 0.
   baby_beat_sequencer_digit_counter #(.LAST(LAST_DIGIT)) u_digit (
      .clk   (clk),
      .clear (reset | ~active),
      .en    (active),
      .count (digit),
      .tc    (tc)
   );

   assign active    = (state == ST_RUNNING) || (state == ST_STEPPING);
   assign end_instr = active && (beat == LAST_BEAT) && tc;

   always_comb begin
      next_state = state;
      case (state)
         ST_STOPPED: begin
            if (run)            next_state = ST_RUNNING;
            else if (step_rise) next_state = ST_STEPPING;
         end
         ST_RUNNING: begin
            if (end_instr) begin
               if (stop_instr) next_state = ST_HALTED;
               else if (!run)  next_state = ST_STOPPED;
            end
         end
         ST_STEPPING: begin
            if (end_instr) begin
               if (stop_instr) next_state = ST_HALTED;
               else            next_state = ST_STOPPED;
            end
         end
         ST_HALTED: begin
            if (!run) next_state = ST_STOPPED;
         end
         default: next_state = ST_STOPPED;
      endcase
   end

   // Outputs are registered from the next-cycle view of state/beat/digit so
   // they line up with the counter and beat registers.
   always_comb begin
      next_active = (next_state == ST_RUNNING) || (next_state == ST_STEPPING);
      next_digit  = 5'd0;
      next_beat   = 2'd0;
      if (active && next_active) begin
         next_digit = tc ? 5'd0 : digit + 5'd1;
         if (tc) next_beat = (beat == LAST_BEAT) ? 2'd0 : beat + 2'd1;
         else    next_beat = beat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_STOPPED;
         beat       <= BEAT_SCAN1;
         ci_inc_en  <= 1'b0;
         pi_load_en <= 1'b0;
         opnd_en    <= 1'b0;
         exec_en    <= 1'b0;
         instr_done <= 1'b0;
         stopped    <= 1'b1;
      end else begin
         state      <= next_state;
         beat       <= next_beat;
         ci_inc_en  <= next_active && (next_beat == BEAT_SCAN1);
         pi_load_en <= next_active && (next_beat == BEAT_ACTION1);
         opnd_en    <= next_active && (next_beat == BEAT_SCAN2);
         exec_en    <= next_active && (next_beat == BEAT_ACTION2);
         instr_done <= next_active && (next_beat == LAST_BEAT) &&
                       (next_digit == LAST_DIGIT);
         stopped    <= ~next_active;
      end
   end

   assign fsm_state = state;

endmodule
